pp_generator: RTL

PP_GENERATOR -- requirements
Module: pp_generator

---
 rtl/pp_generator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pp_generator.sv
// Partial-product row generator for an 8x8 unsigned multiplier.
// Captures an operand pair, builds the eight column-compressed AND rows
// ROWS_PER_CYCLE at a time, then publishes them all at once on p0..p7.
module pp_generator #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [14:0] p0,
  output logic [12:0] p1,
  output logic [10:0] p2,
  output logic [8:0]  p3,
  output logic [6:0]  p4,
  output logic [4:0]  p5,
  output logic [2:0]  p6,
  output logic [0:0]  p7,
  output logic        out_valid,
  output logic        busy
);

  // Reject unsupported build widths at elaboration time.
  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 ||
        ROWS_PER_CYCLE == 4 || ROWS_PER_CYCLE == 8)) begin : g_bad_rows
    $error("pp_generator: ROWS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [3:0]  r_cnt;
  // All eight rows are packed back to back: row i starts at bit i*(16-i)
  // and is 15-2i bits wide, 64 bits in total.
  logic [63:0] r_work;
  logic [63:0] r_p;
  logic [63:0] w_terms;
  logic [63:0] w_work_next;
  logic        w_zero;
  logic        w_last;

  assign w_zero = (a == 8'd0) || (b == 8'd0);
  assign w_last = ((r_cnt + 4'(ROWS_PER_CYCLE)) == 4'd8);

  // Every row is formed from the captured operands; the row counter only
  // decides which rows are latched into the working register this cycle.
  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    localparam int W   = 15 - 2 * gi;
    localparam int OFF = gi * (16 - gi);
    logic w_sel;

    assign w_sel = (4'(gi) >= r_cnt) && (4'(gi) < (r_cnt + 4'(ROWS_PER_CYCLE)));

    for (genvar gk = 0; gk < W; gk++) begin : g_bit
      localparam int C = gi + gk;
      localparam int J = ((C > 7) ? (C - 7) : 0) + gi;
      assign w_terms[OFF + gk] = r_a[J] & r_b[C - J];
    end

    assign w_work_next[OFF +: W] = w_sel ? w_terms[OFF +: W] : r_work[OFF +: W];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_state_next = w_zero ? S_DONE : S_GEN;
        end
      end
      S_GEN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, row building and result publication.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= 8'd0;
      r_b    <= 8'd0;
      r_cnt  <= 4'd0;
      r_work <= 64'd0;
      r_p    <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_cnt <= 4'd0;
            if (w_zero) begin
              // Product is zero: skip generation and publish empty rows now.
              r_work <= 64'd0;
              r_p    <= 64'd0;
            end
          end
        end
        S_GEN: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt + 4'(ROWS_PER_CYCLE);
          if (w_last) begin
            r_p <= w_work_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign p0 = r_p[0  +: 15];
  assign p1 = r_p[15 +: 13];
  assign p2 = r_p[28 +: 11];
  assign p3 = r_p[39 +: 9];
  assign p4 = r_p[48 +: 7];
  assign p5 = r_p[55 +: 5];
  assign p6 = r_p[60 +: 3];
  assign p7 = r_p[63 +: 1];

endmodule
